// File: rtl/hack_pkg.sv
// Shared word-level types and sizes for the Hack memory tiers.
package hack_pkg;
    localparam int WORD_W      = 16;
    localparam int RAM8_DEPTH  = 8;
    localparam int RAM8_ADDR_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    function automatic logic [RAM8_DEPTH-1:0] onehot8(input logic [RAM8_ADDR_W-1:0] sel);
        return RAM8_DEPTH'(1) << sel;
    endfunction
endpackage

// File: rtl/ram8_mux8way16.sv
// 8-way WIDTH-bit selector; the read path of ram8.
module mux8way16 #(
    parameter int WIDTH = hack_pkg::WORD_W
) (
    input  logic [7:0][WIDTH-1:0] in,
    input  logic [2:0]            sel,
    output logic [WIDTH-1:0]      out
);
    assign out = in[sel];
endmodule

// File: rtl/ram8_register16.sv
// One WIDTH-bit load register with synchronous active-high clear.
module register16 #(
    parameter int WIDTH = hack_pkg::WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in;
        end
    end

    // Clear wins over load so a write in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;
endmodule

// File: rtl/ram8.sv
// Eight-word RAM: one-hot write decode into register16 cells, mux8way16 read.
module ram8
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = RAM8_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out
);
    logic [DEPTH-1:0]            load_strobe;
    logic [DEPTH-1:0][WIDTH-1:0] words;

    // No strobe at all when load is low, exactly one otherwise.
    assign load_strobe = load ? onehot8(address) : '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        register16 #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .in    (in),
            .load  (load_strobe[k]),
            .out   (words[k])
        );
    end

    mux8way16 #(.WIDTH(WIDTH)) u_mux (
        .in  (words),
        .sel (address),
        .out (out)
    );
endmodule
